// File: rtl/vga_dac_pkg.sv
// rtl/vga_dac_pkg.sv - shared constants and helpers for the VGA DAC front end
package vga_dac_pkg;

    localparam int         NCH_DEF        = 3;
    localparam int         IN_BITS_DEF    = 8;
    localparam int         DAC_BITS_DEF   = 8;
    localparam int         BW_DEF         = 3;
    localparam int         PIPE_DEF       = 1;
    localparam logic [2:0] BIAS_RST_DEF   = 3'd4;
    localparam bit         COMMIT_VBL_DEF = 1'b1;

    typedef struct packed {
        logic [7:0]  dd;
        logic [31:0] sat_mask;
    } dither_cfg_t;

    // cfg_sel code that addresses every channel at once
    function automatic logic [31:0] bcast_sel(input int nch);
        return 32'(nch);
    endfunction

    // Number of dithered low bits and the all-ones clamp value for the DAC code
    function automatic dither_cfg_t dither_cfg(input int in_bits, input int dac_bits);
        dither_cfg_t c;
        c.dd       = 8'(in_bits - dac_bits);
        c.sat_mask = (dac_bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << dac_bits) - 32'd1);
        return c;
    endfunction

endpackage

// File: rtl/vga_dac_dither.sv
// rtl/vga_dac_dither.sv - per-channel temporal dither, blank gating and stage-1 register
module vga_dac_dither
    import vga_dac_pkg::*;
#(
    parameter int IN_BITS  = IN_BITS_DEF,
    parameter int DAC_BITS = DAC_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                blank_i,
    input  logic [IN_BITS-1:0]  pix_i,
    output logic [DAC_BITS-1:0] q_o
);

    localparam dither_cfg_t         CFG = dither_cfg(IN_BITS, DAC_BITS);
    localparam int                  DD  = int'(CFG.dd);
    localparam logic [DAC_BITS-1:0] SAT = CFG.sat_mask[DAC_BITS-1:0];

    logic [DAC_BITS-1:0] q_d;
    logic [DAC_BITS-1:0] q_q;

    generate
        if (DD == 0) begin : g_pass
            // Equal widths: the code is the input word, zeroed during blank
            always_comb q_d = blank_i ? '0 : pix_i;
        end else begin : g_dith
            logic [DD-1:0]     res_q;
            logic [DD-1:0]     res_d;
            logic [DD:0]       sum;
            logic [DAC_BITS:0] qx;

            // Add the residual to the dropped bits; the carry rounds the code up, clamped at full scale
            always_comb begin
                sum   = {1'b0, res_q} + {1'b0, pix_i[DD-1:0]};
                qx    = {1'b0, pix_i[IN_BITS-1:DD]} + {{DAC_BITS{1'b0}}, sum[DD]};
                q_d   = qx[DAC_BITS] ? SAT : qx[DAC_BITS-1:0];
                res_d = res_q;
                if (blank_i) begin
                    q_d = '0;
                end else begin
                    res_d = sum[DD-1:0];
                end
            end

            // Residual is frozen through blanking so the sequence resumes where it stopped
            always_ff @(posedge clk) begin
                if (rst) begin
                    res_q <= '0;
                end else begin
                    res_q <= res_d;
                end
            end
        end
    endgenerate

    // Stage-1 code register
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/vga_dac_frontend.sv
// rtl/vga_dac_frontend.sv - latency-matched DAC codes, Vbias shadow/commit and PMOD outputs
module vga_dac_frontend
    import vga_dac_pkg::*;
#(
    parameter int             NCH        = NCH_DEF,
    parameter int             IN_BITS    = IN_BITS_DEF,
    parameter int             DAC_BITS   = DAC_BITS_DEF,
    parameter int             BW         = BW_DEF,
    parameter int             PIPE       = PIPE_DEF,
    parameter logic [BW-1:0]  BIAS_RST   = BW'(BIAS_RST_DEF),
    parameter bit             COMMIT_VBL = COMMIT_VBL_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_hsync,
    input  logic                       in_vsync,
    input  logic                       in_hblank,
    input  logic                       in_vblank,
    input  logic [NCH*IN_BITS-1:0]     in_rgb,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [$clog2(NCH+1)-1:0]   cfg_sel,
    input  logic [BW-1:0]              cfg_bias,
    output logic                       cfg_pending,
    output logic [NCH*DAC_BITS-1:0]    dac,
    output logic [NCH*BW-1:0]          bias,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       hblank,
    output logic                       vblank,
    output logic [7:0]                 uo_out
);

    localparam int            SW        = $clog2(NCH + 1);
    localparam logic [SW-1:0] SEL_BCAST = SW'(bcast_sel(NCH));
    localparam int            D         = DAC_BITS;
    localparam int            SLW       = NCH * DAC_BITS + 4;

    logic                    blank;
    logic [NCH*DAC_BITS-1:0] q_s1;
    logic [3:0]              tim_q;
    logic [SLW-1:0]          s1;
    logic [SLW-1:0]          s_out;

    assign blank = in_hblank | in_vblank;

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_dith
            vga_dac_dither #(
                .IN_BITS  (IN_BITS),
                .DAC_BITS (DAC_BITS)
            ) u_dither (
                .clk     (clk),
                .rst     (rst),
                .blank_i (blank),
                .pix_i   (in_rgb[k*IN_BITS +: IN_BITS]),
                .q_o     (q_s1[k*DAC_BITS +: DAC_BITS])
            );
        end
    endgenerate

    // Stage-1 timing register, aligned with the dither output register
    always_ff @(posedge clk) begin
        if (rst) begin
            tim_q <= '0;
        end else begin
            tim_q <= {in_hsync, in_vsync, in_hblank, in_vblank};
        end
    end

    assign s1 = {tim_q, q_s1};

    generate
        if (PIPE == 1) begin : g_p1
            assign s_out = s1;
        end else begin : g_pn
            logic [SLW-1:0] dly_q [PIPE-1];

            // Pure delay stages after stage 1; reset discards everything in flight
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < PIPE - 1; i++) dly_q[i] <= '0;
                end else begin
                    dly_q[0] <= s1;
                    for (int i = 1; i < PIPE - 1; i++) dly_q[i] <= dly_q[i-1];
                end
            end

            assign s_out = dly_q[PIPE-2];
        end
    endgenerate

    assign {hsync, vsync, hblank, vblank, dac} = s_out;

    assign uo_out = {hsync, dac[3*D-2], dac[2*D-2], dac[D-2],
                     vsync, dac[3*D-1], dac[2*D-1], dac[D-1]};

    logic [BW-1:0]  shadow_q [NCH];
    logic [BW-1:0]  shadow_d [NCH];
    logic [BW-1:0]  active_q [NCH];
    logic [BW-1:0]  active_d [NCH];
    logic [NCH-1:0] pend_q;
    logic [NCH-1:0] pend_d;
    logic [NCH-1:0] hit;
    logic           vbl_q;
    logic           cfg_pending_q;
    logic           accept;
    logic           commit_edge;

    assign cfg_ready   = !rst;
    assign accept      = cfg_valid && cfg_ready;
    assign commit_edge = in_vblank && !vbl_q;

    // Shadow capture and commit; a write landing on the vblank edge goes straight to active
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            hit[k]      = accept && ((cfg_sel == SW'(k)) || (cfg_sel == SEL_BCAST));
            shadow_d[k] = hit[k] ? cfg_bias : shadow_q[k];
            active_d[k] = active_q[k];
            if (COMMIT_VBL) begin
                pend_d[k] = pend_q[k] | hit[k];
                if (commit_edge && pend_d[k]) begin
                    active_d[k] = shadow_d[k];
                    pend_d[k]   = 1'b0;
                end
            end else begin
                pend_d[k] = hit[k];
                if (pend_q[k]) active_d[k] = shadow_q[k];
            end
        end
    end

    // Bias state registers; reset drops any uncommitted shadow value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= BIAS_RST;
            end
            pend_q        <= '0;
            vbl_q         <= 1'b0;
            cfg_pending_q <= 1'b0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                shadow_q[k] <= shadow_d[k];
                active_q[k] <= active_d[k];
            end
            pend_q        <= pend_d;
            vbl_q         <= in_vblank;
            cfg_pending_q <= |pend_d;
        end
    end

    assign cfg_pending = cfg_pending_q;

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_bias
            assign bias[k*BW +: BW] = active_q[k];
        end
    endgenerate

endmodule

// File: tb/tb_vga_dac_frontend.sv
// tb/tb_vga_dac_frontend.sv - self-checking bench for vga_dac_frontend
module tb_vga_dac_frontend;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_hsync, in_vsync, in_hblank, in_vblank, cfg_valid;
    logic [23:0] in_rgb;
    logic [1:0]  cfg_sel;
    logic [2:0]  cfg_bias;

    logic        rdy0, pnd0, hs0, vs0, hb0, vb0;
    logic [23:0] dac0;
    logic [8:0]  bias0;
    logic [7:0]  uo0;
    logic        rdy1, pnd1, hs1, vs1, hb1, vb1;
    logic [17:0] dac1;
    logic [8:0]  bias1;
    logic [7:0]  uo1;

    int total = 0;
    int bad   = 0;

    vga_dac_frontend #(
        .NCH(3), .IN_BITS(8), .DAC_BITS(8), .BW(3), .PIPE(1), .BIAS_RST(3'd4), .COMMIT_VBL(1'b1)
    ) dut0 (
        .clk(clk), .rst(rst), .in_hsync(in_hsync), .in_vsync(in_vsync), .in_hblank(in_hblank),
        .in_vblank(in_vblank), .in_rgb(in_rgb), .cfg_valid(cfg_valid), .cfg_ready(rdy0),
        .cfg_sel(cfg_sel), .cfg_bias(cfg_bias), .cfg_pending(pnd0), .dac(dac0), .bias(bias0),
        .hsync(hs0), .vsync(vs0), .hblank(hb0), .vblank(vb0), .uo_out(uo0)
    );

    vga_dac_frontend #(
        .NCH(3), .IN_BITS(8), .DAC_BITS(6), .BW(3), .PIPE(4), .BIAS_RST(3'd4), .COMMIT_VBL(1'b0)
    ) dut1 (
        .clk(clk), .rst(rst), .in_hsync(in_hsync), .in_vsync(in_vsync), .in_hblank(in_hblank),
        .in_vblank(in_vblank), .in_rgb(in_rgb), .cfg_valid(cfg_valid), .cfg_ready(rdy1),
        .cfg_sel(cfg_sel), .cfg_bias(cfg_bias), .cfg_pending(pnd1), .dac(dac1), .bias(bias1),
        .hsync(hs1), .vsync(vs1), .hblank(hb1), .vblank(vb1), .uo_out(uo1)
    );

    // Reference model: history of pixels (newest at index 0) plus bias bookkeeping
    logic [3:0]  m_tim [4];
    logic [23:0] m_d0  [4];
    logic [17:0] m_d1  [4];
    int          m_res [3];
    logic [2:0]  sh0 [3], act0 [3], due1 [3], act1 [3];
    bit          pd0 [3], has_due1 [3];
    bit          vprev;

    always @(posedge clk) begin : model
        int          v, tot, q;
        logic [23:0] n0;
        logic [17:0] n1;
        bit          blk, wr;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_tim[i] = '0; m_d0[i] = '0; m_d1[i] = '0;
            end
            for (int c = 0; c < 3; c++) begin
                m_res[c] = 0; sh0[c] = 3'd0; act0[c] = 3'd4; pd0[c] = 1'b0;
                act1[c] = 3'd4; due1[c] = 3'd0; has_due1[c] = 1'b0;
            end
            vprev = 1'b0;
        end else begin
            blk = in_hblank | in_vblank;
            for (int c = 0; c < 3; c++) begin
                v = int'(in_rgb[c*8 +: 8]);
                n0[c*8 +: 8] = blk ? 8'd0 : 8'(v);
                if (blk) begin
                    q = 0;
                end else begin
                    tot = m_res[c] + v % 4;
                    q   = v / 4 + tot / 4;
                    if (q > 63) q = 63;
                    m_res[c] = tot % 4;
                end
                n1[c*6 +: 6] = 6'(q);
            end
            for (int i = 3; i > 0; i--) begin
                m_tim[i] = m_tim[i-1]; m_d0[i] = m_d0[i-1]; m_d1[i] = m_d1[i-1];
            end
            m_tim[0] = {in_hsync, in_vsync, in_hblank, in_vblank};
            m_d0[0]  = n0;
            m_d1[0]  = n1;
            // VBL-gated instance: collect writes, release them on the vblank rise
            for (int c = 0; c < 3; c++) begin
                wr = cfg_valid && (int'(cfg_sel) == c || cfg_sel == 2'd3);
                if (wr) begin sh0[c] = cfg_bias; pd0[c] = 1'b1; end
            end
            if (in_vblank && !vprev) begin
                for (int c = 0; c < 3; c++) if (pd0[c]) begin act0[c] = sh0[c]; pd0[c] = 1'b0; end
            end
            vprev = in_vblank;
            // Immediate instance: a write becomes active one edge after the edge that took it
            for (int c = 0; c < 3; c++) if (has_due1[c]) begin act1[c] = due1[c]; has_due1[c] = 1'b0; end
            for (int c = 0; c < 3; c++) begin
                wr = cfg_valid && (int'(cfg_sel) == c || cfg_sel == 2'd3);
                if (wr) begin due1[c] = cfg_bias; has_due1[c] = 1'b1; end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; in_hsync = 0; in_vsync = 0; in_hblank = 0; in_vblank = 0;
        in_rgb = '0; cfg_valid = 0; cfg_sel = '0; cfg_bias = '0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_hsync = 0; in_vsync = 0; in_hblank = 0; in_vblank = 0;
        in_rgb = '0; cfg_valid = 0; cfg_sel = '0; cfg_bias = '0;
        cyc(); cyc();
        total++; if (bias0 !== 9'h124) begin bad++; $display("FAIL reset_bias0 got=%h exp=124", bias0); end
        total++; if (bias1 !== 9'h124) begin bad++; $display("FAIL reset_bias1 got=%h exp=124", bias1); end
        total++; if (dac0 !== 24'h0 || uo0 !== 8'h0) begin bad++; $display("FAIL reset_out0 dac=%h uo=%h exp=0", dac0, uo0); end
        total++; if ({hs0, vs0, hb0, vb0, pnd0} !== 5'b0) begin bad++; $display("FAIL reset_tim0 got=%b exp=0", {hs0, vs0, hb0, vb0, pnd0}); end
        total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", rdy0); end
    endtask

    task automatic test_passthrough();
        rst = 1'b0; in_rgb = 24'h123456; in_hsync = 1; in_vsync = 1;
        cyc();
        total++; if (dac0 !== 24'h123456) begin bad++; $display("FAIL pass_dac got=%h exp=123456", dac0); end
        total++; if (uo0 !== 8'h98) begin bad++; $display("FAIL pass_uo got=%h exp=98", uo0); end
        total++; if (hs0 !== 1'b1 || vs0 !== 1'b1) begin bad++; $display("FAIL pass_sync got=%b%b exp=11", hs0, vs0); end
        total++; if (dac1 !== 18'h0) begin bad++; $display("FAIL pass_pipe4_empty got=%h exp=0", dac1); end
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL pass_ready got=%b exp=1", rdy0); end
        in_hsync = 0; in_vsync = 0;
    endtask

    task automatic test_dither();
        logic [5:0] e;
        reset_dut();
        in_rgb = 24'h050505;
        for (int k = 0; k < 15; k++) begin
            cyc();
            if (k >= 3) begin
                e = ((k - 3) % 4 == 3) ? 6'd2 : 6'd1;
                total++; if (dac1 !== {3{e}}) begin bad++; $display("FAIL dither_seq k=%0d got=%h exp=%h", k, dac1, {3{e}}); end
            end
        end
        total++; if (dac0 !== 24'h050505) begin bad++; $display("FAIL dither_full got=%h exp=050505", dac0); end
        in_rgb = 24'hFFFFFF;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (k >= 4) begin
                total++; if (dac1 !== 18'h3FFFF) begin bad++; $display("FAIL dither_sat k=%0d got=%h exp=3ffff", k, dac1); end
            end
        end
    endtask

    task automatic test_blank_freeze();
        int         exp_q [8];
        logic [5:0] e;
        bit         bl;
        exp_q = '{1, 1, 0, 0, 0, 1, 2, 1};
        reset_dut();
        in_rgb = 24'h050505;
        for (int k = 0; k < 11; k++) begin
            in_hblank = (k >= 2 && k < 5);
            cyc();
            total++; if (dac0 !== (in_hblank ? 24'h0 : 24'h050505)) begin bad++; $display("FAIL blank_dac0 k=%0d got=%h", k, dac0); end
            if (k >= 3) begin
                e  = 6'(exp_q[k-3]);
                bl = (k - 3 >= 2 && k - 3 < 5);
                total++; if (dac1 !== {3{e}}) begin bad++; $display("FAIL blank_dac1 k=%0d got=%h exp=%h", k, dac1, {3{e}}); end
                total++; if (hb1 !== bl) begin bad++; $display("FAIL blank_hb1 k=%0d got=%b exp=%b", k, hb1, bl); end
            end
        end
        in_hblank = 0;
    endtask

    task automatic test_latency();
        reset_dut();
        for (int k = 0; k < 10; k++) begin
            in_hsync = (k == 0); in_vsync = (k == 1); in_hblank = (k == 2); in_vblank = (k == 3);
            in_rgb = (k == 4) ? 24'hFFFFFF : 24'h0;
            cyc();
            total++; if ({hs1, vs1, hb1, vb1} !== {k == 3, k == 4, k == 5, k == 6}) begin bad++; $display("FAIL lat_tim1 k=%0d got=%b", k, {hs1, vs1, hb1, vb1}); end
            total++; if (dac1 !== ((k == 7) ? 18'h3FFFF : 18'h0)) begin bad++; $display("FAIL lat_dac1 k=%0d got=%h", k, dac1); end
            total++; if ({hs0, vs0, hb0, vb0} !== {k == 0, k == 1, k == 2, k == 3}) begin bad++; $display("FAIL lat_tim0 k=%0d got=%b", k, {hs0, vs0, hb0, vb0}); end
        end
        in_hsync = 0; in_vsync = 0; in_hblank = 0; in_vblank = 0; in_rgb = '0;
    endtask

    task automatic test_bias_vbl();
        reset_dut();
        cfg_valid = 1; cfg_sel = 2'd1; cfg_bias = 3'd7;
        cyc();
        cfg_valid = 0;
        total++; if (pnd0 !== 1'b1 || bias0 !== 9'h124) begin bad++; $display("FAIL vbl_wait pend=%b bias=%h exp=1/124", pnd0, bias0); end
        for (int k = 0; k < 4; k++) cyc();
        total++; if (pnd0 !== 1'b1 || bias0 !== 9'h124) begin bad++; $display("FAIL vbl_hold pend=%b bias=%h exp=1/124", pnd0, bias0); end
        in_vblank = 1;
        cyc();
        total++; if (bias0 !== 9'h13C || pnd0 !== 1'b0) begin bad++; $display("FAIL vbl_commit bias=%h pend=%b exp=13c/0", bias0, pnd0); end
        cyc();
        in_vblank = 0;
        cyc();
        cfg_valid = 1; cfg_sel = 2'd3; cfg_bias = 3'd2;
        cyc();
        cfg_valid = 0;
        total++; if (bias0 !== 9'h13C || pnd0 !== 1'b1) begin bad++; $display("FAIL bcast_wait bias=%h pend=%b exp=13c/1", bias0, pnd0); end
        in_vblank = 1;
        cyc();
        total++; if (bias0 !== 9'h092 || pnd0 !== 1'b0) begin bad++; $display("FAIL bcast_commit bias=%h pend=%b exp=092/0", bias0, pnd0); end
    endtask

    task automatic test_edge_write();
        in_vblank = 0;
        cyc();
        in_vblank = 1; cfg_valid = 1; cfg_sel = 2'd0; cfg_bias = 3'd5;
        cyc();
        cfg_valid = 0;
        total++; if (bias0 !== 9'h095 || pnd0 !== 1'b0) begin bad++; $display("FAIL edge_write bias=%h pend=%b exp=095/0", bias0, pnd0); end
        cyc();
        total++; if (pnd0 !== 1'b0) begin bad++; $display("FAIL edge_nopend got=%b exp=0", pnd0); end
        in_vblank = 0;
    endtask

    task automatic test_bias_immediate();
        reset_dut();
        cfg_valid = 1; cfg_sel = 2'd2; cfg_bias = 3'd6;
        cyc();
        cfg_valid = 0;
        total++; if (bias1 !== 9'h124 || pnd1 !== 1'b1) begin bad++; $display("FAIL imm_wait bias=%h pend=%b exp=124/1", bias1, pnd1); end
        cyc();
        total++; if (bias1 !== 9'h1A4 || pnd1 !== 1'b0) begin bad++; $display("FAIL imm_commit bias=%h pend=%b exp=1a4/0", bias1, pnd1); end
        total++; if (bias0 !== 9'h124 || pnd0 !== 1'b1) begin bad++; $display("FAIL imm_vbl_side bias=%h pend=%b exp=124/1", bias0, pnd0); end
    endtask

    task automatic test_reset_pending();
        in_rgb = 24'hFFFFFF;
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        total++; if (bias0 !== 9'h124 || pnd0 !== 1'b0) begin bad++; $display("FAIL rstp_bias bias=%h pend=%b exp=124/0", bias0, pnd0); end
        total++; if (dac1 !== 18'h0) begin bad++; $display("FAIL rstp_dac1 got=%h exp=0", dac1); end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            total++; if (dac1 !== ((k == 3) ? 18'h3FFFF : 18'h0)) begin bad++; $display("FAIL rstp_flush k=%0d got=%h", k, dac1); end
        end
        in_vblank = 1;
        cyc();
        cyc();
        total++; if (bias0 !== 9'h124 || pnd0 !== 1'b0) begin bad++; $display("FAIL rstp_nocommit bias=%h pend=%b exp=124/0", bias0, pnd0); end
        in_vblank = 0; in_rgb = '0;
    endtask

    task automatic test_random(input int n);
        logic [23:0] ed0;
        logic [17:0] ed1;
        logic [3:0]  et0, et1;
        logic [7:0]  eu0, eu1;
        logic [8:0]  eb0, eb1;
        for (int k = 0; k < n; k++) begin
            rst       = ($urandom_range(0, 63) == 0);
            in_hsync  = 1'($urandom_range(0, 1));
            in_vsync  = 1'($urandom_range(0, 1));
            in_hblank = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) in_vblank = ~in_vblank;
            in_rgb    = 24'($urandom);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_sel   = 2'($urandom_range(0, 3));
            cfg_bias  = 3'($urandom_range(0, 7));
            cyc();
            ed0 = m_d0[0]; et0 = m_tim[0];
            ed1 = m_d1[3]; et1 = m_tim[3];
            eu0 = {et0[3], ed0[22], ed0[14], ed0[6], et0[2], ed0[23], ed0[15], ed0[7]};
            eu1 = {et1[3], ed1[16], ed1[10], ed1[4], et1[2], ed1[17], ed1[11], ed1[5]};
            eb0 = {act0[2], act0[1], act0[0]};
            eb1 = {act1[2], act1[1], act1[0]};
            total++; if ({hs0, vs0, hb0, vb0, dac0} !== {et0, ed0}) begin bad++; $display("FAIL rand_out0 k=%0d got=%h exp=%h", k, {hs0, vs0, hb0, vb0, dac0}, {et0, ed0}); end
            total++; if ({hs1, vs1, hb1, vb1, dac1} !== {et1, ed1}) begin bad++; $display("FAIL rand_out1 k=%0d got=%h exp=%h", k, {hs1, vs1, hb1, vb1, dac1}, {et1, ed1}); end
            total++; if (uo0 !== eu0 || uo1 !== eu1) begin bad++; $display("FAIL rand_uo k=%0d got=%h/%h exp=%h/%h", k, uo0, uo1, eu0, eu1); end
            total++; if (bias0 !== eb0 || bias1 !== eb1) begin bad++; $display("FAIL rand_bias k=%0d got=%h/%h exp=%h/%h", k, bias0, bias1, eb0, eb1); end
            total++; if (pnd0 !== (pd0[0] | pd0[1] | pd0[2]) || pnd1 !== (has_due1[0] | has_due1[1] | has_due1[2])) begin
                bad++; $display("FAIL rand_pending k=%0d got=%b/%b", k, pnd0, pnd1);
            end
            total++; if (rdy0 !== !rst || rdy1 !== !rst) begin bad++; $display("FAIL rand_ready k=%0d got=%b/%b rst=%b", k, rdy0, rdy1, rst); end
        end
        rst = 1'b0; cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_dither();
        test_blank_freeze();
        test_latency();
        test_bias_vbl();
        test_edge_write();
        test_bias_immediate();
        test_reset_pending();
        test_random(400);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/vga_dac_frontend.md
# vga_dac_frontend

Parametrised pipeline stage between the VGA pattern controller and the analog R/G/B DACs. It takes raw sync, blank and colour words and produces registered, latency-matched DAC codes. Where the DAC is narrower than the colour source, per-channel temporal dithering fills the gap. Per-channel Vbias codes are written through a handshake and committed glitch-free at the start of vertical blanking. It also drives the digital TinyVGA PMOD (RGB222) outputs from the same registered data.

## Interface
Parameters:
- `NCH`, 3: number of colour channels; channel 0=R, 1=G, 2=B; must be ≥3.
- `IN_BITS`, 8: colour bits per channel at the input.
- `DAC_BITS`, 8: DAC code bits per channel; 2 ≤ DAC_BITS ≤ IN_BITS.
- `BW`, 3: Vbias code bits per channel.
- `PIPE`, 1: output latency in cycles; range 1–4.
- `BIAS_RST`, 3'd4: active Vbias code after reset, per channel.
- `COMMIT_VBL`, 1: 1 = bias commits at the vblank rising edge; 0 = bias commits on the cycle after the write.

Ports:
- `clk`  in  1  pixel clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_hsync`, `in_vsync`, `in_hblank`, `in_vblank`  in  1 each  timing from the controller.
- `in_rgb`  in  NCH*IN_BITS  colour, channel k at bits [k*IN_BITS +: IN_BITS].
- `cfg_valid`  in  1  bias write request.
- `cfg_ready`  out  1  bias write accepted when valid&&ready.
- `cfg_sel`  in  $clog2(NCH+1)  target channel; value NCH broadcasts to all channels.
- `cfg_bias`  in  BW  bias code.
- `cfg_pending`  out  1  at least one shadow value is not yet committed.
- `dac`  out  NCH*DAC_BITS  DAC codes.
- `bias`  out  NCH*BW  active Vbias codes.
- `hsync`, `vsync`, `hblank`, `vblank`  out  1 each  delayed timing.
- `uo_out`  out  8  {hsync, c2[D-2], c1[D-2], c0[D-2], vsync, c2[D-1], c1[D-1], c0[D-1]}, D=DAC_BITS, taken from the `dac` output.

## Operation
- Blank = in_hblank | in_vblank, sampled at the input.
- Dither, with Dd = IN_BITS−DAC_BITS:
  - Each channel has a residual `res` of Dd bits, reset to 0.
  - sum = res + in[Dd-1:0], computed in Dd+1 bits.
  - q = in[IN-1:Dd] + sum[Dd]; q saturates at all-ones, and no wrap is permitted.
  - res ← sum[Dd-1:0] on non-blank cycles only; res is held during blank.
  - When Dd=0: q = in and no residual is generated.
- Blank gating: q is forced to 0 on blank cycles.
- Pipeline:
  - Stage 1 registers q and the four timing bits.
  - Stages 2..PIPE are pure delay.
  - All outputs are delayed equally.
- Bias write:
  - cfg_ready = !rst, i.e. always ready out of reset.
  - An accepted write stores cfg_bias in the shadow register of the selected channel (or all channels) and sets that channel's pending bit.
  - A cfg_sel value greater than NCH is accepted and ignored.
- Bias commit:
  - COMMIT_VBL=1: on the cycle where in_vblank is 1 and its previous registered value is 0, every pending channel copies shadow→active and clears its pending bit.
  - COMMIT_VBL=0: commit happens on the cycle after the accepted write.
  - A write and a commit edge in the same cycle: the written value is committed in that same cycle, and its pending bit ends at 0.
  - Two writes to the same channel before a commit: the last write wins.
- cfg_pending = OR of all pending bits, registered.

## Timing
- Reset values:
  - dac, hsync, vsync, hblank, vblank, uo_out, cfg_pending: 0.
  - bias = BIAS_RST on every channel.
  - Residuals, shadow registers and pending bits: 0; the vblank-edge register is cleared to 0.
- Latency: input at cycle t appears on all data/timing outputs at t+PIPE.
- bias changes exactly 1 cycle after the commit condition.
  - COMMIT_VBL=1: bias changes on the first output clock edge after the vblank edge is seen at the input, independent of PIPE.
  - COMMIT_VBL=0: bias changes 2 cycles after the accepted write.
- Reset asserted mid-frame:
  - Pipeline contents are discarded.
  - Outputs read their reset values from the next edge.
  - A pending shadow is lost and is never committed.
- A vblank already high when reset is released does not commit; only a 0→1 transition commits.

## Structure
- Package `vga_dac_pkg`:
  - Default parameter constants.
  - The `cfg_sel` broadcast encoding.
  - A function returning Dd and the saturation mask.
- Sub-module `vga_dac_dither`:
  - One instance per channel, parameterised by IN_BITS/DAC_BITS.
  - Holds the residual and blank gating, and produces the stage-1 register.
- The top level holds the delay line, the bias shadow/active/pending registers, the vblank edge detect and the uo_out mapping.

## Test plan
- Reset with IN=DAC=8, PIPE=1, in_rgb=0x123456, no blank → dac=0x123456 and uo_out matches the bit mapping 1 cycle later; bias=3'd4×3 during reset.
- IN=8, DAC=6, constant channel value 0x05 (q base 1, low bits 01), no blank → outputs repeat the sequence 1,1,1,2 per 4 pixels; value 0xFF → constant 63, with no wrap to 0.
- Blank asserted for 3 cycles with value 0x05 → dac=0 for those cycles, the residual is frozen, and the dither sequence resumes where it stopped.
- COMMIT_VBL=1: write sel=1 bias=7 mid-line → cfg_pending=1 and bias is unchanged until the vblank rise; the next cycle G bias=7, cfg_pending=0. Broadcast sel=3 bias=2 → all channels =2 at the next vblank.
- Write issued on the exact cycle of the vblank rising edge → committed the same cycle, and cfg_pending never rises. COMMIT_VBL=0 → bias updates 2 cycles after the write.
- PIPE=4: check the latency of all timing bits and the DAC code is 4. Assert rst while a write is pending → bias returns to 4, and no commit occurs at the next vblank.
